// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: reset vector, PC step,
// fetch FSM states, next-PC selection codes and the NOP encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Which action wins on the coming edge while fetching
    typedef enum logic [1:0] {
        SEL_HALT     = 2'd0,
        SEL_REDIRECT = 2'd1,
        SEL_STALL    = 2'd2,
        SEL_SEQ      = 2'd3
    } fetch_sel_e;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// next_pc_sel: combinational next-PC mux for the fetch stage.
// Priority: halt_req > redirect_valid > stall > sequential increment.
// Redirect targets are forced to word alignment; a non-aligned target is
// flagged so the parent can record it.
module next_pc_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_INC = PC_INC_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output fetch_sel_e  sel,
    output logic [31:0] next_pc,
    output logic        target_misaligned
);

    // Pick the winning action and the PC it produces
    always_comb begin
        sel               = SEL_SEQ;
        next_pc           = pc + PC_INC;
        target_misaligned = 1'b0;
        if (halt_req) begin
            sel     = SEL_HALT;
            next_pc = pc;
        end else if (redirect_valid) begin
            sel               = SEL_REDIRECT;
            next_pc           = word_align(redirect_target);
            target_misaligned = (redirect_target[1:0] != 2'b00);
        end else if (stall) begin
            sel     = SEL_STALL;
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the MIPS core.
// Owns the PC, drives the word address to instruction_memory (same-cycle
// return) and captures the result into the IF/ID register. Handles stall,
// branch/jump redirect and halt on the exit syscall.
// Optional feature macro: BRANCH_DELAY_SLOT_EN -- when defined, the
// instruction fetched alongside a redirect is kept as the delay slot;
// otherwise it is flushed from IF/ID.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        halted,
    output logic        misaligned
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    fetch_sel_e   sel;
    logic         target_misaligned;

    next_pc_sel #(
        .PC_INC(PC_INC)
    ) u_next_pc_sel (
        .pc               (pc),
        .halt_req         (halt_req),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .stall            (stall),
        .sel              (sel),
        .next_pc          (next_pc),
        .target_misaligned(target_misaligned)
    );

    // Address 0 while halted makes the memory return a NOP
    assign imem_addr = (state == HALT) ? 32'h0000_0000 : pc;

    // PC, fetch FSM and IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            ifid_valid    <= 1'b0;
            ifid_pc       <= 32'h0000_0000;
            ifid_pc_plus4 <= 32'h0000_0000;
            ifid_instr    <= NOP_WORD;
            halted        <= 1'b0;
            misaligned    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    pc <= next_pc;
                    case (sel)
                        SEL_HALT: begin
                            state      <= HALT;
                            halted     <= 1'b1;
                            ifid_valid <= 1'b0;
                            ifid_instr <= NOP_WORD;
                        end
                        SEL_REDIRECT: begin
                            if (target_misaligned) begin
                                misaligned <= 1'b1;
                            end
`ifdef BRANCH_DELAY_SLOT_EN
                            ifid_valid    <= 1'b1;
                            ifid_pc       <= pc;
                            ifid_pc_plus4 <= pc + 32'd4;
                            ifid_instr    <= imem_instr;
`else
                            ifid_valid    <= 1'b0;
                            ifid_instr    <= NOP_WORD;
`endif
                        end
                        SEL_STALL: begin
                            ifid_valid <= ifid_valid;
                        end
                        default: begin
                            ifid_valid    <= 1'b1;
                            ifid_pc       <= pc;
                            ifid_pc_plus4 <= pc + 32'd4;
                            ifid_instr    <= imem_instr;
                        end
                    endcase
                end
                default: begin
                    state      <= HALT;
                    halted     <= 1'b1;
                    ifid_valid <= 1'b0;
                    ifid_instr <= NOP_WORD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// stall / redirect / halt / reset traffic, checked every cycle against a
// behavioural model of the fetch stage and a synthetic instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic        halted;
    logic        misaligned;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_valid;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_plus4;
    logic [31:0] m_instr;
    logic        m_mis;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_instr     (ifid_instr),
        .halted         (halted),
        .misaligned     (misaligned)
    );

    // Synthetic memory: address 0 reads as NOP, anything else a scrambled word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0040_0000;
        m_halted  = 1'b0;
        m_valid   = 1'b0;
        m_ifid_pc = 32'h0;
        m_plus4   = 32'h0;
        m_instr   = 32'h0;
        m_mis     = 1'b0;
    endtask

    task automatic model_capture();
        m_ifid_pc = m_pc;
        m_plus4   = m_pc + 32'd4;
        m_instr   = mem_word(m_pc);
        m_valid   = 1'b1;
    endtask

    // One clock edge of the fetch stage, straight from the behavioural rules
    task automatic model_edge();
        logic [31:0] tgt;
        if (m_halted) return;
        if (halt_req) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
            m_instr  = 32'h0;
        end else if (redirect_valid) begin
            tgt = redirect_target;
            if (tgt % 4 != 0) m_mis = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
            model_capture();
`else
            m_valid = 1'b0;
            m_instr = 32'h0;
`endif
            m_pc = tgt - (tgt % 4);
        end else if (!stall) begin
            model_capture();
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  imem_addr, m_halted ? 32'h0 : m_pc);
        chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
        chk({tag, ".pc"},    ifid_pc, m_ifid_pc);
        chk({tag, ".pc4"},   ifid_pc_plus4, m_plus4);
        chk({tag, ".instr"}, ifid_instr, m_instr);
        chk({tag, ".halt"},  {31'b0, halted}, {31'b0, m_halted});
        chk({tag, ".mis"},   {31'b0, misaligned}, {31'b0, m_mis});
    endtask

    // Called at a negedge with inputs already driven
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt_req        = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // 1: reset and sequential fetch
        check_all("rst");
        chk("t1_addr0", imem_addr, 32'h0040_0000);
        rst = 1'b0;
        step("t1a");
        chk("t1_ifid_pc", ifid_pc, 32'h0040_0000);
        chk("t1_pc4", ifid_pc_plus4, 32'h0040_0004);
        chk("t1_valid", {31'b0, ifid_valid}, 32'd1);
        chk("t1_addr1", imem_addr, 32'h0040_0004);
        step("t1b");
        chk("t1_addr2", imem_addr, 32'h0040_0008);

        // 2: three-cycle stall at 0x00400008
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t2s");
            chk("t2_addr_hold", imem_addr, 32'h0040_0008);
            chk("t2_pc_hold", ifid_pc, 32'h0040_0004);
        end
        stall = 1'b0;
        step("t2r");
        chk("t2_resume", imem_addr, 32'h0040_000C);
        step("t2n");

        // 3: redirect at 0x00400010
        chk("t3_at", imem_addr, 32'h0040_0010);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0100;
        step("t3");
        chk("t3_addr", imem_addr, 32'h0040_0100);
`ifdef BRANCH_DELAY_SLOT_EN
        chk("t3_ds_pc", ifid_pc, 32'h0040_0010);
        chk("t3_ds_valid", {31'b0, ifid_valid}, 32'd1);
`else
        chk("t3_flush_valid", {31'b0, ifid_valid}, 32'd0);
        chk("t3_flush_instr", ifid_instr, 32'd0);
`endif

        // 4: redirect with stall, misaligned target, then sticky flag
        stall           = 1'b1;
        redirect_target = 32'h0040_0203;
        step("t4a");
        chk("t4_addr", imem_addr, 32'h0040_0200);
        chk("t4_mis", {31'b0, misaligned}, 32'd1);
        stall           = 1'b0;
        redirect_target = 32'h0040_0020;
        step("t4b");
        chk("t4_sticky", {31'b0, misaligned}, 32'd1);
        redirect_valid = 1'b0;

        // 5: halt at 0x00400020, ignore redirects afterwards
        chk("t5_at", imem_addr, 32'h0040_0020);
        halt_req = 1'b1;
        step("t5h");
        halt_req        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0100;
        for (int i = 0; i < 10; i++) step("t5w");
        chk("t5_halted", {31'b0, halted}, 32'd1);
        chk("t5_addr", imem_addr, 32'h0);
        chk("t5_valid", {31'b0, ifid_valid}, 32'd0);

        // 6: async reset while halted
        redirect_valid = 1'b0;
        async_reset("t6");
        chk("t6_addr", imem_addr, 32'h0040_0000);
        chk("t6_halted", {31'b0, halted}, 32'd0);

        // Wrap-around and fetch at address 0
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step("wr0");
        redirect_valid = 1'b0;
        step("wr1");
        chk("wrap_addr", imem_addr, 32'h0);
        step("wr2");
        chk("wrap_pc0", ifid_pc, 32'h0);
        chk("wrap_valid", {31'b0, ifid_valid}, 32'd1);
        chk("wrap_instr", ifid_instr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            stall          = ($urandom % 4) == 0;
            redirect_valid = ($urandom % 6) == 0;
            halt_req       = ($urandom % 50) == 0;
            case ($urandom % 4)
                0: redirect_target = 32'h0040_0000 + ($urandom % 1024);
                1: redirect_target = 32'hFFFF_FFF0 + ($urandom % 16);
                2: redirect_target = $urandom % 16;
                default: redirect_target = $urandom;
            endcase
            if (m_halted && ($urandom % 8) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
